// File: rtl/sram_1p_ctrl.sv
// Load/store controller for one single-port SRAM with a two-cycle registered read.
// Define SRAM_CTRL_RMW_EN to turn partial byte-enable stores into read-modify-write.
module sram_1p_ctrl #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_W-1:0]     req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   input  logic [DATA_W/8-1:0]   req_be,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_W-1:0]     rsp_rdata,
   output logic                  sram_en,
   output logic                  sram_we,
   output logic [ADDR_W-1:0]     sram_addr,
   output logic [DATA_W-1:0]     sram_wdata,
   input  logic [DATA_W-1:0]     sram_rdata
);

   typedef enum logic [2:0] {IDLE, WR, RD_A, RD_B, CAP, RSP} state_t;

   state_t            state;
   logic              accept;
   logic              start_rd;
   logic              start_wr;
   logic              start_rmw;
   logic              is_rmw;
   logic [DATA_W-1:0] merged;

   assign accept = req_valid & req_ready;

`ifdef SRAM_CTRL_RMW_EN
   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] st_wdata;
   logic [BE_W-1:0]   st_be;

   // NOTE: pure datapath holding registers; they are only read after an accept loads them, so no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         st_wdata <= req_wdata;
         st_be    <= req_be;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         is_rmw <= 1'b0;
      else if (state == IDLE && accept)
         is_rmw <= start_rmw;
   end

   always_comb begin
      // NOTE: default first, then overrides, so no path leaves merged unassigned and no latch is inferred.
      merged = sram_rdata;
      for (int b = 0; b < BE_W; b++)
         if (st_be[b]) merged[8*b +: 8] = st_wdata[8*b +: 8];
   end

   always_comb begin
      start_rd  = accept & ~req_we;
      start_wr  = accept & req_we & (&req_be);
      start_rmw = accept & req_we & (|req_be) & ~(&req_be);
   end
`else
   logic unused_be;

   assign unused_be = ^req_be;
   assign is_rmw    = 1'b0;
   assign merged    = sram_rdata;

   // Byte enables are ignored: every store writes the whole word.
   always_comb begin
      start_rd  = accept & ~req_we;
      start_wr  = accept & req_we;
      start_rmw = 1'b0;
   end
`endif

   // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         sram_en    <= 1'b0;
         sram_we    <= 1'b0;
         sram_addr  <= '0;
         sram_wdata <= '0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start_wr) begin
                  state      <= WR;
                  req_ready  <= 1'b0;
                  sram_en    <= 1'b1;
                  sram_we    <= 1'b1;
                  sram_addr  <= req_addr;
                  sram_wdata <= req_wdata;
               end else if (start_rd | start_rmw) begin
                  state     <= RD_A;
                  req_ready <= 1'b0;
                  sram_en   <= 1'b1;
                  sram_we   <= 1'b0;
                  sram_addr <= req_addr;
               end else begin
                  // Also covers the first cycle after reset and zero-enable stores.
                  req_ready <= 1'b1;
               end
            end
            WR: begin
               state     <= IDLE;
               sram_en   <= 1'b0;
               sram_we   <= 1'b0;
               req_ready <= 1'b1;
            end
            RD_A: state <= RD_B;
            RD_B: begin
               state   <= CAP;
               sram_en <= 1'b0;
            end
            CAP: begin
               if (is_rmw) begin
                  state      <= WR;
                  sram_en    <= 1'b1;
                  sram_we    <= 1'b1;
                  sram_wdata <= merged;
               end else begin
                  state     <= RSP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= sram_rdata;
               end
            end
            RSP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               sram_en   <= 1'b0;
               sram_we   <= 1'b0;
               rsp_valid <= 1'b0;
               req_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
